// File: rtl/otter_mem_responder_pkg.sv
// Shared bus package for the otter_bus interface and the memory responder:
// bus field widths, responder state encoding and the address-range helper.
package otter_mem_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  // Range is computed one bit wider so base+span cannot wrap at the top of the map.
  function automatic logic addr_is_bad(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W:0]   span_bytes);
    logic [ADDR_W:0] top;
    top = {1'b0, base} + span_bytes;
    return (addr < base) || ({1'b0, addr} >= top) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/otter_mem_responder_if.sv
// otter_bus: single-outstanding request/acknowledge memory bus.
// primary drives the request fields, secondary returns ack/rdata/err.
interface otter_bus;
  import otter_mem_responder_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport primary (
    output req, we, addr, wdata, wstrb,
    input  ack, rdata, err
  );

  modport secondary (
    input  req, we, addr, wdata, wstrb,
    output ack, rdata, err
  );
endinterface

// File: rtl/otter_mem_responder_sram.sv
// otter_sram: synchronous single-port RAM with per-byte write enable.
// Read is registered and returns the contents before a same-edge write.
module otter_sram
  import otter_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic                           we,
  input  logic [STRB_W-1:0]              be,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/otter_mem_responder.sv
// otter_mem_responder: wait-state memory target on otter_bus with byte-lane writes.
// Define OTTER_MEM_RESP_ERR_EN to flag misaligned/out-of-range accesses with err.
module otter_mem_responder
  import otter_mem_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned       DEPTH_WORDS = 4096,
  parameter int unsigned       WAIT_STATES = 1
) (
  input  logic         clk,
  input  logic         rst,
  otter_bus.secondary  bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [ADDR_W:0] SPAN_BYTES = (ADDR_W+1)'(64'(DEPTH_WORDS) * 64'd4);

  resp_state_t       state;
  logic [3:0]        cnt;
  logic              ack_q;
  logic              err_q;
  logic              we_l;
  logic              err_l;
  logic [AW-1:0]     idx_l;
  logic [DATA_W-1:0] wdata_l;
  logic [STRB_W-1:0] wstrb_l;

  logic [AW-1:0]     idx_live;
  logic              err_live;
  logic [AW-1:0]     sram_addr;
  logic              sram_we;
  logic [DATA_W-1:0] sram_q;

  assign idx_live = AW'((bus.addr - BASE_ADDR) >> 2);

`ifdef OTTER_MEM_RESP_ERR_EN
  assign err_live = addr_is_bad(bus.addr, BASE_ADDR, SPAN_BYTES);
`else
  assign err_live = 1'b0;
`endif

  // The RAM read must launch on the edge that enters RESP; with zero wait
  // states that is the accept edge itself, so IDLE addresses from the live bus.
  assign sram_addr = (state == IDLE) ? idx_live : idx_l;
  assign sram_we   = (state == RESP) && we_l && !err_l;

  otter_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk  (clk),
    .addr (sram_addr),
    .we   (sram_we),
    .be   (wstrb_l),
    .wdata(wdata_l),
    .rdata(sram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      we_l    <= 1'b0;
      err_l   <= 1'b0;
      idx_l   <= '0;
      wdata_l <= '0;
      wstrb_l <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.req) begin
            we_l    <= bus.we;
            err_l   <= err_live;
            idx_l   <= idx_live;
            wdata_l <= bus.wdata;
            wstrb_l <= bus.wstrb;
            if (WAIT_STATES == 0) begin
              state <= RESP;
              ack_q <= 1'b1;
              err_q <= err_live;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            ack_q <= 1'b1;
            err_q <= err_l;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = (ack_q && !err_q) ? sram_q : '0;

endmodule

// File: doc/otter_mem_responder.md
OTTER_MEM_RESPONDER -- requirements
Module: otter_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096: 32-bit words of storage; power of two, at least 16.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15: extra cycles inserted before acknowledge.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port bus, otter_bus.secondary: carries req (1), we (1), addr (32), wdata (32), wstrb (4) in; ack (1), rdata (32), err (1) out.

Function
REQ-007 SHALL use states IDLE, WAIT and RESP; reset state IDLE.
REQ-008 SHALL accept a transaction in IDLE when req=1: latch addr, we, wdata and wstrb; ignore later input changes until ack.
REQ-009 SHALL go from IDLE to RESP when WAIT_STATES=0, otherwise to WAIT with a 4-bit counter loaded to WAIT_STATES-1.
REQ-010 SHALL decrement the counter in WAIT and go to RESP in the cycle after the counter reads 0.
REQ-011 SHALL drive ack=1 for exactly one cycle, in RESP, then return to IDLE.
REQ-012 SHALL give a latency of WAIT_STATES+1 cycles from the accept edge to ack; back-to-back requests leave one IDLE cycle between acks.
REQ-013 SHALL ignore req while in WAIT or RESP; a req still high in the IDLE cycle after RESP starts a new transaction.
REQ-014 SHALL compute the word index as (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
REQ-015 SHALL commit a write in the RESP cycle, writing only the byte lanes whose wstrb bit is 1; wstrb=0 is a legal no-op.
REQ-016 SHALL present read data on rdata in the RESP cycle, equal to memory contents before any same-cycle write; rdata is 0 outside RESP.
REQ-017 SHALL hold ack=0, err=0 and rdata=0 in IDLE and WAIT.

Reset
REQ-018 SHALL, on rst low at any time, force IDLE, counter 0, ack=0, err=0 and rdata=0 immediately.
REQ-019 SHALL drop a transaction interrupted by reset in WAIT, with no memory write; memory contents are not reset.
REQ-020 SHALL start accepting requests on the first rising edge after rst is released.

Configuration
REQ-021 SHALL, with OTTER_MEM_RESP_ERR_EN defined, flag a transaction as an error when addr is below BASE_ADDR, at or above BASE_ADDR+4*DEPTH_WORDS, or has addr[1:0]!=0.
REQ-022 SHALL, for an errored transaction, suppress the write, drive rdata=0 and drive err=1 together with ack, keeping the same latency.
REQ-023 SHALL, without OTTER_MEM_RESP_ERR_EN, tie err to 0, ignore addr[1:0] and let out-of-range addresses alias through index truncation.

Structure
REQ-024 SHALL take the state enum (resp_state_t) and the response field widths from the shared bus package used by the otter_bus interface.
REQ-025 SHALL place storage in one sub-module, otter_sram: a synchronous single-port RAM with per-byte write enable, instantiated once.

Verification
REQ-026 SHALL cover: WAIT_STATES=1, write addr 0x10 data 0xDEADBEEF wstrb 4'hF, then read 0x10 -> ack 2 cycles after each accept, rdata 0xDEADBEEF.
REQ-027 SHALL cover: word 0x20 preset to 0x11223344, write data 0xAABBCCDD wstrb 4'b0101, then read -> rdata 0x11BB33DD.
REQ-028 SHALL cover: WAIT_STATES=0 with req held high for 3 transactions -> ack on cycles 1, 3 and 5 after the first accept, never on consecutive cycles.
REQ-029 SHALL cover: rst pulsed low during WAIT of a write to 0x40 -> ack never asserts, word 0x40 unchanged, next request serviced normally.
REQ-030 SHALL cover: ERR_EN defined, DEPTH_WORDS=16, write to 0x40 and read of 0x02 -> err=1 with ack, rdata 0, memory unchanged.
REQ-031 SHALL cover: ERR_EN undefined, same accesses as REQ-030 -> err stays 0; the write to 0x40 aliases to word 0.
